uart_word_loader: RTL and testbench

//  Receives a program image over UART and writes it into instruction memory.

---
 rtl/uart_word_loader_pkg.sv | 28 ++
 rtl/uart_rx_core.sv | 124 ++++++++++++
 rtl/uart_word_loader.sv | 147 ++++++++++++++
 tb/tb_uart_word_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_loader_pkg.sv
// Shared definitions for the UART word loader: parity codes, RX state encoding,
// default baud divider and the parity check helper.
package uart_word_loader_pkg;

    localparam int PARITY_NONE          = 0;
    localparam int PARITY_ODD           = 1;
    localparam int PARITY_EVEN          = 2;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    function automatic logic parity_ok(input logic [7:0] data, input logic par_bit, input int mode);
        logic ones_odd;
        ones_odd = ^data ^ par_bit;
        case (mode)
            PARITY_ODD:  parity_ok = ones_odd;
            PARITY_EVEN: parity_ok = ~ones_odd;
            default:     parity_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchroniser, start-bit qualification, LSB-first data,
// optional parity and stop-bit check. All status outputs are single-cycle pulses.
module uart_rx_core
    import uart_word_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       en,
    output logic       rx_idle,
    output logic       start_ok,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             sync_p0, sync_p1, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_bit;

    assign rx_idle = (state == RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            start_ok   <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sync_p0    <= uart_rx;
            sync_p1    <= sync_p0;
            rx_prev    <= sync_p1;
            start_ok   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (!en) begin
                state   <= RX_IDLE;
                clk_cnt <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (rx_prev && !sync_p1) begin
                            state   <= RX_START;
                            clk_cnt <= '0;
                        end
                    end
                    // Resample mid start bit so short glitches are rejected.
                    RX_START: begin
                        if (clk_cnt == HALF_LAST) begin
                            clk_cnt <= '0;
                            if (sync_p1) begin
                                state <= RX_IDLE;
                            end else begin
                                state    <= RX_DATA;
                                bit_idx  <= '0;
                                start_ok <= 1'b1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (clk_cnt == FULL_LAST) begin
                            clk_cnt <= '0;
                            shift   <= {sync_p1, shift[7:1]};
                            if (bit_idx == 3'd7) state <= (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    RX_PAR: begin
                        if (clk_cnt == FULL_LAST) begin
                            clk_cnt <= '0;
                            par_bit <= sync_p1;
                            state   <= RX_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (clk_cnt == FULL_LAST) begin
                            clk_cnt <= '0;
                            state   <= RX_IDLE;
                            if (!sync_p1) begin
                                frame_err <= 1'b1;
                            end else if (!parity_ok(shift, par_bit, PARITY)) begin
                                parity_err <= 1'b1;
                            end else begin
                                byte_valid <= 1'b1;
                                byte_data  <= shift;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Program-image loader: assembles received bytes into words, writes them to
// instruction memory with a ready handshake and holds the CPU in reset meanwhile.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY         = PARITY_NONE,
    parameter int BYTES_PER_WORD = 4,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int ADDR_W         = 12,
    parameter int IDLE_TIMEOUT   = 500000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    input  logic                        en,
    output logic                        wr_en,
    input  logic                        wr_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [8*BYTES_PER_WORD-1:0] wr_data,
    output logic                        loading,
    output logic                        done,
    output logic [ADDR_W:0]             word_count,
    output logic                        err_frame,
    output logic                        err_parity,
    output logic                        err_overflow
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TO_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]   MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_WORD = MEM_WORDS - 1'b1;
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(IDLE_TIMEOUT);

    logic              rx_idle, start_ok, byte_valid, frame_err, parity_err;
    logic [7:0]        byte_data;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] word_buf, word_next;
    logic [TO_W-1:0]   to_cnt;
    logic              ending;
    logic              accept, full_after, can_issue;
    logic [ADDR_W:0]   count_after;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY      (PARITY)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .en        (en),
        .rx_idle   (rx_idle),
        .start_ok  (start_ok),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always_comb begin
        word_next = word_buf;
        if (BIG_ENDIAN) word_next[(BYTES_PER_WORD - 1 - int'(byte_idx)) * 8 +: 8] = byte_data;
        else            word_next[int'(byte_idx) * 8 +: 8] = byte_data;
    end

    // A write accepted this cycle frees the slot for a word completing in the same cycle.
    assign accept      = wr_en && wr_ready;
    assign count_after = word_count + {{ADDR_W{1'b0}}, accept};
    assign full_after  = (count_after == MEM_WORDS);
    assign can_issue   = (!wr_en || accept) && !full_after;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            loading      <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
            err_frame    <= 1'b0;
            err_parity   <= 1'b0;
            err_overflow <= 1'b0;
            byte_idx     <= '0;
            to_cnt       <= '0;
            ending       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (loading && !en) begin
                loading  <= 1'b0;
                ending   <= 1'b0;
                wr_en    <= 1'b0;
                byte_idx <= '0;
            end else if (!loading) begin
                if (start_ok && en) begin
                    loading      <= 1'b1;
                    err_frame    <= 1'b0;
                    err_parity   <= 1'b0;
                    err_overflow <= 1'b0;
                    word_count   <= '0;
                    wr_addr      <= '0;
                    byte_idx     <= '0;
                    to_cnt       <= '0;
                end
            end else begin
                if (accept) begin
                    wr_en      <= 1'b0;
                    word_count <= word_count + 1'b1;
                    if (word_count != LAST_WORD) wr_addr <= wr_addr + 1'b1;
                end
                if (frame_err && !ending)  err_frame  <= 1'b1;
                if (parity_err && !ending) err_parity <= 1'b1;
                if (byte_valid && !ending) begin
                    word_buf <= word_next;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx <= '0;
                        if (can_issue) begin
                            wr_en   <= 1'b1;
                            wr_data <= word_next;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                // Idle timeout closes the session once any pending write drains.
                if (ending) begin
                    if (!wr_en || accept) begin
                        ending  <= 1'b0;
                        loading <= 1'b0;
                        done    <= 1'b1;
                    end
                end else if (!rx_idle || byte_valid) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LIMIT) begin
                    ending   <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: three instances (8N1 big-endian,
// 8N1 little-endian, even parity) driven by an LSB-first UART frame task.
module tb_uart_word_loader;

    localparam int CPB = 16;
    localparam int TO  = 400;
    localparam int AW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx           [3];
    logic        en           [3];
    logic        wr_ready     [3];
    logic        wr_en        [3];
    logic [AW-1:0] wr_addr    [3];
    logic [31:0] wr_data      [3];
    logic        loading      [3];
    logic        done         [3];
    logic [AW:0] word_count   [3];
    logic        err_frame    [3];
    logic        err_parity   [3];
    logic        err_overflow [3];

    logic [31:0]   log_data [3][16];
    logic [AW-1:0] log_addr [3][16];
    int            wcnt [3];
    int            dcnt [3];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .PARITY(0), .BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1),
                       .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut_be (
        .clk(clk), .rst(rst), .uart_rx(rx[0]), .en(en[0]), .wr_en(wr_en[0]), .wr_ready(wr_ready[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .loading(loading[0]), .done(done[0]),
        .word_count(word_count[0]), .err_frame(err_frame[0]), .err_parity(err_parity[0]),
        .err_overflow(err_overflow[0]));

    uart_word_loader #(.CLKS_PER_BIT(CPB), .PARITY(0), .BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0),
                       .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut_le (
        .clk(clk), .rst(rst), .uart_rx(rx[1]), .en(en[1]), .wr_en(wr_en[1]), .wr_ready(wr_ready[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .loading(loading[1]), .done(done[1]),
        .word_count(word_count[1]), .err_frame(err_frame[1]), .err_parity(err_parity[1]),
        .err_overflow(err_overflow[1]));

    uart_word_loader #(.CLKS_PER_BIT(CPB), .PARITY(2), .BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1),
                       .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut_par (
        .clk(clk), .rst(rst), .uart_rx(rx[2]), .en(en[2]), .wr_en(wr_en[2]), .wr_ready(wr_ready[2]),
        .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .loading(loading[2]), .done(done[2]),
        .word_count(word_count[2]), .err_frame(err_frame[2]), .err_parity(err_parity[2]),
        .err_overflow(err_overflow[2]));

    // Write and done-pulse recorder, sampled on the falling edge.
    initial for (int i = 0; i < 3; i++) begin wcnt[i] = 0; dcnt[i] = 0; end
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i] && wr_ready[i]) begin
                if (wcnt[i] < 16) begin
                    log_data[i][wcnt[i]] = wr_data[i];
                    log_addr[i][wcnt[i]] = wr_addr[i];
                end
                wcnt[i]++;
            end
            if (done[i]) dcnt[i]++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input int ch, input logic v);
        rx[ch] = v;
        cyc(CPB);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b, input bit use_par,
                             input logic par, input logic stop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, b[i]);
        if (use_par) send_bit(ch, par);
        send_bit(ch, stop);
        rx[ch] = 1'b1;
        cyc(CPB);
    endtask

    task automatic send_word(input int ch, input logic [31:0] w, input bit use_par);
        logic [7:0] b;
        for (int i = 3; i >= 0; i--) begin
            b = w[i*8 +: 8];
            send_byte(ch, b, use_par, ^b, 1'b1);
        end
    endtask

    task automatic wait_end(input int ch, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!loading[ch]) begin ok = 1'b1; break; end
        end
        cyc(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin rx[i] = 1'b1; en[i] = 1'b0; wr_ready[i] = 1'b0; end
        cyc(4);
        @(negedge clk);
        n_tests++; if ({wr_en[0], loading[0], done[0]} !== 3'b000) begin n_fail++;
            $display("FAIL reset_ctrl got %b want 000", {wr_en[0], loading[0], done[0]}); end
        n_tests++; if ({err_frame[0], err_parity[0], err_overflow[0]} !== 3'b000) begin n_fail++;
            $display("FAIL reset_err got %b want 000", {err_frame[0], err_parity[0], err_overflow[0]}); end
        n_tests++; if (wr_addr[0] !== '0 || wr_data[0] !== 32'h0 || word_count[0] !== '0) begin n_fail++;
            $display("FAIL reset_data got addr=%h data=%h cnt=%0d want 0", wr_addr[0], wr_data[0], word_count[0]); end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic_be();
        int w0, d0;
        bit ok;
        w0 = wcnt[0]; d0 = dcnt[0];
        en[0] = 1'b1; wr_ready[0] = 1'b1;
        send_word(0, 32'h0010_0093, 1'b0);
        n_tests++; if (loading[0] !== 1'b1) begin n_fail++;
            $display("FAIL be_loading got %b want 1", loading[0]); end
        send_word(0, 32'h0020_0113, 1'b0);
        wait_end(0, 1500, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL be_timeout_end got loading=1 want 0"); end
        n_tests++; if (wcnt[0] - w0 !== 2) begin n_fail++;
            $display("FAIL be_writes got %0d want 2", wcnt[0] - w0); end
        n_tests++; if (log_data[0][w0] !== 32'h0010_0093 || log_addr[0][w0] !== 4'd0) begin n_fail++;
            $display("FAIL be_word0 got %h@%0d want 00100093@0", log_data[0][w0], log_addr[0][w0]); end
        n_tests++; if (log_data[0][w0+1] !== 32'h0020_0113 || log_addr[0][w0+1] !== 4'd1) begin n_fail++;
            $display("FAIL be_word1 got %h@%0d want 00200113@1", log_data[0][w0+1], log_addr[0][w0+1]); end
        n_tests++; if (word_count[0] !== 5'd2) begin n_fail++;
            $display("FAIL be_count got %0d want 2", word_count[0]); end
        n_tests++; if (dcnt[0] - d0 !== 1) begin n_fail++;
            $display("FAIL be_done got %0d pulses want 1", dcnt[0] - d0); end
    endtask

    task automatic test_little_endian();
        int w0;
        bit ok;
        w0 = wcnt[1];
        en[1] = 1'b1; wr_ready[1] = 1'b1;
        send_word(1, 32'h9300_1000, 1'b0);
        wait_end(1, 1500, ok);
        n_tests++; if (!ok || wcnt[1] - w0 !== 1) begin n_fail++;
            $display("FAIL le_writes got %0d ended=%b want 1 ended=1", wcnt[1] - w0, ok); end
        n_tests++; if (log_data[1][w0] !== 32'h0010_0093 || log_addr[1][w0] !== 4'd0) begin n_fail++;
            $display("FAIL le_word got %h@%0d want 00100093@0", log_data[1][w0], log_addr[1][w0]); end
    endtask

    task automatic test_parity();
        int w0;
        bit ok;
        w0 = wcnt[2];
        en[2] = 1'b1; wr_ready[2] = 1'b1;
        send_byte(2, 8'h01, 1'b1, 1'b0, 1'b1);
        send_word(2, 32'hDEAD_BEEF, 1'b1);
        n_tests++; if (err_parity[2] !== 1'b1 || err_frame[2] !== 1'b0) begin n_fail++;
            $display("FAIL par_err got par=%b frame=%b want 1 0", err_parity[2], err_frame[2]); end
        wait_end(2, 1500, ok);
        n_tests++; if (!ok || wcnt[2] - w0 !== 1) begin n_fail++;
            $display("FAIL par_writes got %0d ended=%b want 1 ended=1", wcnt[2] - w0, ok); end
        n_tests++; if (log_data[2][w0] !== 32'hDEAD_BEEF || word_count[2] !== 5'd1) begin n_fail++;
            $display("FAIL par_word got %h cnt=%0d want deadbeef cnt=1", log_data[2][w0], word_count[2]); end
    endtask

    task automatic test_frame_error();
        int w0;
        bit ok;
        w0 = wcnt[0];
        send_byte(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h55, 1'b0, 1'b0, 1'b0);
        send_byte(0, 8'h10, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h93, 1'b0, 1'b0, 1'b1);
        wait_end(0, 1500, ok);
        n_tests++; if (err_frame[0] !== 1'b1) begin n_fail++;
            $display("FAIL frame_err got %b want 1", err_frame[0]); end
        n_tests++; if (!ok || wcnt[0] - w0 !== 1 || log_data[0][w0] !== 32'h0010_0093) begin n_fail++;
            $display("FAIL frame_word got n=%0d data=%h want n=1 00100093", wcnt[0] - w0, log_data[0][w0]); end
    endtask

    task automatic test_overflow();
        int w0;
        bit ok;
        w0 = wcnt[0];
        wr_ready[0] = 1'b0;
        send_word(0, 32'h1122_3344, 1'b0);
        @(negedge clk);
        n_tests++; if (wr_en[0] !== 1'b1 || wr_data[0] !== 32'h1122_3344 || wr_addr[0] !== 4'd0) begin n_fail++;
            $display("FAIL ovf_hold1 got en=%b %h@%0d want 1 11223344@0", wr_en[0], wr_data[0], wr_addr[0]); end
        send_word(0, 32'h5566_7788, 1'b0);
        @(negedge clk);
        n_tests++; if (wr_en[0] !== 1'b1 || wr_data[0] !== 32'h1122_3344 || err_overflow[0] !== 1'b1) begin n_fail++;
            $display("FAIL ovf_hold2 got en=%b data=%h ovf=%b want 1 11223344 1", wr_en[0], wr_data[0], err_overflow[0]); end
        wr_ready[0] = 1'b1;
        cyc(3);
        n_tests++; if (wcnt[0] - w0 !== 1 || log_addr[0][w0] !== 4'd0 || log_data[0][w0] !== 32'h1122_3344) begin n_fail++;
            $display("FAIL ovf_write got n=%0d %h@%0d want 1 11223344@0", wcnt[0] - w0, log_data[0][w0], log_addr[0][w0]); end
        n_tests++; if (wr_en[0] !== 1'b0 || word_count[0] !== 5'd1 || wr_addr[0] !== 4'd1) begin n_fail++;
            $display("FAIL ovf_after got en=%b cnt=%0d addr=%0d want 0 1 1", wr_en[0], word_count[0], wr_addr[0]); end
        wait_end(0, 1500, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_end got loading=1 want 0"); end
    endtask

    task automatic test_abort_and_reset();
        int w0, d0;
        logic [7:0] b;
        w0 = wcnt[0];
        send_word(0, 32'h0102_0304, 1'b0);
        send_word(0, 32'h0506_0708, 1'b0);
        d0 = dcnt[0];
        b = 8'hA5;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, b[i]);
        en[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (loading[0] !== 1'b0 || wr_en[0] !== 1'b0) begin n_fail++;
            $display("FAIL abort_next got loading=%b wr_en=%b want 0 0", loading[0], wr_en[0]); end
        rx[0] = 1'b1;
        cyc(600);
        n_tests++; if (dcnt[0] - d0 !== 0 || word_count[0] !== 5'd2 || wcnt[0] - w0 !== 2) begin n_fail++;
            $display("FAIL abort_state got done=%0d cnt=%0d writes=%0d want 0 2 2", dcnt[0] - d0, word_count[0], wcnt[0] - w0); end
        en[0] = 1'b1;
        send_byte(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        w0 = wcnt[0];
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        n_tests++; if ({wr_en[0], loading[0], done[0], err_frame[0], err_parity[0], err_overflow[0]} !== 6'b0) begin n_fail++;
            $display("FAIL rst_mid_ctrl got %b want 000000",
                     {wr_en[0], loading[0], done[0], err_frame[0], err_parity[0], err_overflow[0]}); end
        n_tests++; if (wr_addr[0] !== '0 || wr_data[0] !== 32'h0 || word_count[0] !== '0 || wcnt[0] !== w0) begin n_fail++;
            $display("FAIL rst_mid_data got addr=%0d data=%h cnt=%0d writes+=%0d want 0",
                     wr_addr[0], wr_data[0], word_count[0], wcnt[0] - w0); end
        rst = 1'b0;
        rx[0] = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_basic_be();
        test_little_endian();
        test_parity();
        test_frame_error();
        test_overflow();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
